// File: rtl/seq_cmp_pkg.sv
// Shared constants for the chunked sequential comparator.
package seq_cmp_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // One-hot result encoding, bit order {lt, gt, eq}
  localparam logic [2:0] RES_EQ = 3'b001;
  localparam logic [2:0] RES_GT = 3'b010;
  localparam logic [2:0] RES_LT = 3'b100;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_cmp_chunk.sv
// Combinational CHUNK-bit compare; msb_signed orders the chunk as two's complement.
module cmp_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             msb_signed,
  output logic             eq,
  output logic             gt
);

  logic [CHUNK-1:0] flip;
  logic [CHUNK-1:0] xs;
  logic [CHUNK-1:0] ys;

  // Flipping the sign bit of both sides turns a signed compare into an unsigned one
  assign flip = msb_signed ? (CHUNK'(1) << (CHUNK - 1)) : '0;
  assign xs   = x ^ flip;
  assign ys   = y ^ flip;
  assign eq   = (x == y);
  assign gt   = (xs > ys);

endmodule

// File: rtl/seq_cmp.sv
// Multi-cycle magnitude/equality comparator, MSB chunk first with early exit.
// Optional two's-complement ordering enabled by SEQ_CMP_SIGNED_EN.
module seq_cmp
  import seq_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
`ifdef SEQ_CMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic             aeqb,
  output logic             agtb,
  output logic             altb
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  logic [0:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic [2:0]       res_q, res_d;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic             msb_signed;
  logic             c_eq;
  logic             c_gt;
  logic             sgn_in;

`ifdef SEQ_CMP_SIGNED_EN
  assign sgn_in = signed_mode;
`else
  assign sgn_in = 1'b0;
`endif

  // Select the chunk under test from the captured operands
  always_comb begin
    int unsigned base;
    base    = 32'(idx_q) * CHUNK;
    chunk_a = a_q[base +: CHUNK];
    chunk_b = b_q[base +: CHUNK];
  end

  assign msb_signed = sgn_q && (idx_q == IDX_TOP);

  cmp_chunk #(
    .CHUNK (CHUNK)
  ) u_cmp (
    .x          (chunk_a),
    .y          (chunk_b),
    .msb_signed (msb_signed),
    .eq         (c_eq),
    .gt         (c_gt)
  );

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (start && ready_q) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = b;
          sgn_d   = sgn_in;
          idx_d   = IDX_TOP;
          res_d   = '0;
          ready_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (!c_eq) begin
          res_d   = c_gt ? RES_GT : RES_LT;
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else if (idx_q == '0) begin
          res_d   = RES_EQ;
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_TOP;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign aeqb  = res_q[0];
  assign agtb  = res_q[1];
  assign altb  = res_q[2];

endmodule

// File: tb/tb_seq_cmp.sv
// Scoreboard bench for seq_cmp: checks result one-hot and done latency per operation.
module tb_seq_cmp;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CHUNK  = 4;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;

  typedef struct {
    logic [2:0]  res;
    int unsigned t0;
    int unsigned m;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             sm;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready, done, aeqb, agtb, altb;

  seq_cmp #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk         (clk),
    .reset_n     (rst_n),
    .start       (start),
`ifdef SEQ_CMP_SIGNED_EN
    .signed_mode (sm),
`endif
    .a           (a),
    .b           (b),
    .ready       (ready),
    .done        (done),
    .aeqb        (aeqb),
    .agtb        (agtb),
    .altb        (altb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: full-width compare for the result, XOR scan for the exit chunk
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic s, input int unsigned t0);
    exp_t e;
    logic [WIDTH-1:0] d;
    bit found;
    e.t0 = t0;
    if (x == y) e.res = 3'b001;
    else if (s ? ($signed(x) > $signed(y)) : (x > y)) e.res = 3'b010;
    else e.res = 3'b100;
    e.m = NCHUNK;
    found = 1'b0;
    for (int i = NCHUNK - 1; i >= 0; i--) begin
      d = (x ^ y) >> (i * CHUNK);
      if (!found && d[CHUNK-1:0] != '0) begin
        e.m   = NCHUNK - i;
        found = 1'b1;
      end
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result", {29'd0, altb, agtb, aeqb}, {29'd0, e.res});
        chk("latency", cyc - e.t0, e.m);
      end
    end
  end

  // Called at negedge+1; returns at negedge+1 of the cycle after acceptance
  task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    int k = 0;
    while (!ready && k < 60) begin
      @(negedge clk); #1;
      k++;
    end
    if (!ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
    end else begin
      a = x; b = y; sm = s; start = 1'b1;
      sb.push_back(model(x, y, s, cyc + 1));
      @(negedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int k = 0;
    while (!(sb.size() == 0 && ready) && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    if (!(sb.size() == 0 && ready)) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_res"}, {29'd0, altb, agtb, aeqb}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] ra, rb, rnd;
    int unsigned      kc;
    rst_n = 1'b0; start = 1'b0; sm = 1'b0; a = '0; b = '0;
    #12;
    chk_cleared("reset");
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Equal operands run to the last chunk; MSB difference exits at once
    do_op(16'h1234, 16'h1234, 1'b0);
    drain();
    do_op(16'h8000, 16'h7FFF, 1'b0);
    drain();

    // Result must hold while idle
    do_op(16'h1230, 16'h1234, 1'b0);
    drain();
    repeat (5) begin
      @(negedge clk); #1;
      chk("hold_altb", {31'd0, altb}, 32'd1);
      chk("hold_done", {31'd0, done}, 32'd0);
    end

    // Start while busy is ignored; start in the done cycle is accepted
    do_op(16'h00FF, 16'h00F0, 1'b0);
    a = '0; b = 16'hFFFF; start = 1'b1;
    chk("busy_ready", {31'd0, ready}, 32'd0);
    @(negedge clk); #1;
    chk("busy_ready2", {31'd0, ready}, 32'd0);
    start = 1'b0;
    begin
      int k = 0;
      while (!done && k < 20) begin
        @(negedge clk); #1;
        k++;
      end
    end
    chk("b2b_done_seen", {31'd0, done}, 32'd1);
    chk("b2b_ready", {31'd0, ready}, 32'd1);
    do_op(16'h0000, 16'h0000, 1'b0);
    drain();

    // Reset in the middle of a run discards the in-flight result
    do_op(16'h1234, 16'h1234, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_cleared("midrst");
    sb.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    do_op(16'h0001, 16'h0002, 1'b0);
    drain();

`ifdef SEQ_CMP_SIGNED_EN
    do_op(16'h8000, 16'h7FFF, 1'b1);
    drain();
    do_op(16'h8000, 16'h7FFF, 1'b0);
    drain();
    do_op(16'hF000, 16'hF001, 1'b1);
    drain();
`endif

    // Random back-to-back ops, each differing in a chosen chunk (or equal)
    for (int n = 0; n < 16; n++) begin
      ra = WIDTH'($urandom);
      rb = ra;
      kc = $urandom_range(0, NCHUNK);
      if (kc < NCHUNK) begin
        rnd = WIDTH'($urandom_range(1, (1 << CHUNK) - 1));
        rb  = ra ^ (rnd << (kc * CHUNK));
      end
`ifdef SEQ_CMP_SIGNED_EN
      do_op(ra, rb, 1'($urandom_range(0, 1)));
`else
      do_op(ra, rb, 1'b0);
`endif
    end
    drain();

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
